clock_display_scanner: RTL
==========================

// Module: clock_display_scanner
// PURPOSE
//  Downstream of the HH:MM:SS BCD time counter. Takes its six BCD digits and
//  drives a 6-digit multiplexed common-anode 7-segment display.
//  Digits are double-buffered, so a new time only appears at a frame boundary.
//  Also handles per-digit blink, leading-zero blanking and anti-ghost blanking.
// PARAMETERS
//  SCAN_DIV      50000  clk cycles per digit slot (>=2)
//  BLANK_CYCLES  4      cycles at start of each slot with all outputs off (< SCAN_DIV)
//  BLINK_DIV     64     full frames per blink half-period (>=1)
// PORTS
//  clk         in   1  clock
//  rst         in   1  reset, asynchronous, active-low
//  load        in   1  capture the digit inputs this cycle
//  hours_tens  in   4  BCD digit shown on idx5 (leftmost)
//  hours_units in   4  BCD digit shown on idx4
//  min_tens    in   4  BCD digit shown on idx3
//  min_units   in   4  BCD digit shown on idx2
//  sec_tens    in   4  BCD digit shown on idx1
//  sec_units   in   4  BCD digit shown on idx0 (rightmost)
//  blink_mask  in   6  bit k=1: digit k blanked during blink phase 1
//  lzb_en      in   1  leading-zero blanking of idx5
//  an_n        out  6  anode enables, active-low, one-hot-low; bit k = digit k
//  seg_n       out  7  segments {g,f,e,d,c,b,a}, active-low
//  dp_n        out  1  decimal point, active-low
//  frame_sync  out  1  1-cycle pulse on the first output cycle of slot 0
// BEHAVIOUR
//  Reset (rst=0, async): an_n=6'h3F, seg_n=7'h7F, dp_n=1, frame_sync=0.
//    Also clears: pending and display buffers, pend flag, div, idx,
//    frame counter, blink_phase.
//  Counters:
//    div counts 0..SCAN_DIV-1. When it wraps, idx goes 0..5, then 5->0.
//    When idx wraps 5->0, the frame counter steps 0..BLINK_DIV-1.
//    When the frame counter wraps, blink_phase toggles.
//  Buffering:
//    load=1 -> pending <= digits, pend=1. Last load in a frame wins.
//    Frame-end edge (idx=5 and div=SCAN_DIV-1) with pend or load:
//      display <= load ? digit inputs : pending; pend <= 0.
//    Display never changes mid-frame.
//  Output timing:
//    All outputs are registered and lag the div/idx state by 1 cycle.
//    frame_sync is high on the output cycle corresponding to div=0, idx=0.
//  Per slot (output view):
//    Output cycles 0..BLANK_CYCLES-1: an_n=3F, seg_n=7F, dp_n=1.
//    Remaining cycles: an_n[idx]=0, seg_n=decode(display[idx]).
//  Decode: 0-9 standard segments; 10-15 -> dash (g only, 7'h3F).
//  Digit k is suppressed (an_n all 1, seg_n=7F, dp_n=1 for the whole slot) if
//  either holds:
//    blink_phase=1 and blink_mask[k]=1;
//    k=5 and lzb_en=1 and display hours_tens=0.
//  dp_n=0 only on idx2 and idx4, only when blink_phase=0 and the digit is lit.
//  blink_mask and lzb_en are sampled live each cycle; they are not buffered.
//  Reset mid-frame restarts at idx0/div0 and shows blank digit 0 (zeros).
// TESTING (SCAN_DIV=8, BLANK_CYCLES=2, BLINK_DIV=2)
//  1. Reset: hold rst=0 -> an_n=3F, seg_n=7F, dp_n=1.
//     Release -> frame_sync pulses every 48 cycles.
//  2. load 12:34:56, then wait for the next frame_sync:
//     slot0 cycles 2-7: an_n=3E, seg_n=02.
//     slot5: an_n=1F, seg_n=79.
//     dp_n=0 in slots 2 and 4.
//  3. Two loads in one frame (11:11:11, then 22:22:22):
//     current frame unchanged; next frame shows 22:22:22 only.
//  4. sec_units=4'hA -> slot0 seg_n=3F.
//     lzb_en=1, hours_tens=0 -> an_n[5] stays 1 through slot5.
//  5. blink_mask=6'b000011:
//     frames 0-1: slots 0/1 lit, dp_n=0 on idx2/4.
//     frames 2-3: an_n[1:0] stay 1, dp_n stays 1.
//  6. rst=0 at slot3 div4 -> outputs blank in the same cycle.
//     Release -> restarts at slot0 and shows 00:00:00.

Source files
------------

// File: rtl/clock_display_scanner.sv
// Six-digit multiplexed common-anode 7-segment scanner for an HH:MM:SS BCD time.
// Frame-aligned double buffering, per-digit blink, leading-zero and anti-ghost blanking.
module clock_display_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 4,
    parameter int BLINK_DIV    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] hours_tens,
    input  logic [3:0] hours_units,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_units,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_units,
    input  logic [5:0] blink_mask,
    input  logic       lzb_en,
    output logic [5:0] an_n,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic       frame_sync
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_BLANK = DIV_W'(BLANK_CYCLES);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [2:0]       idx;
    logic [FRM_W-1:0] frame;
    logic             blink_phase;

    logic [23:0] digits_in;
    logic [23:0] pending;
    logic [23:0] display;
    logic        pend;

    logic        slot_end;
    logic        frame_end;
    logic [5:0]  sel;
    logic [3:0]  cur_digit;
    logic [6:0]  cur_seg;
    logic        suppress;
    logic        lit;

    assign digits_in = {hours_tens, hours_units, min_tens, min_units, sec_tens, sec_units};
    assign slot_end  = (div == DIV_LAST);
    assign frame_end = slot_end && (idx == 3'd5);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div         <= '0;
            idx         <= '0;
            frame       <= '0;
            blink_phase <= 1'b0;
        end else if (slot_end) begin
            div <= '0;
            if (idx == 3'd5) begin
                idx <= '0;
                if (frame == FRM_LAST) begin
                    frame       <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame <= frame + 1'b1;
                end
            end else begin
                idx <= idx + 3'd1;
            end
        end else begin
            div <= div + 1'b1;
        end
    end

    // A load on the frame-end cycle bypasses the pending buffer straight to display.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            display <= '0;
            pend    <= 1'b0;
        end else if (frame_end && (pend || load)) begin
            display <= load ? digits_in : pending;
            pend    <= 1'b0;
        end else if (load) begin
            pending <= digits_in;
            pend    <= 1'b1;
        end
    end

    always_comb begin
        sel = 6'b000001 << idx;
        case (idx)
            3'd1:    cur_digit = display[7:4];
            3'd2:    cur_digit = display[11:8];
            3'd3:    cur_digit = display[15:12];
            3'd4:    cur_digit = display[19:16];
            3'd5:    cur_digit = display[23:20];
            default: cur_digit = display[3:0];
        endcase
        case (cur_digit)
            4'd0:    cur_seg = 7'h40;
            4'd1:    cur_seg = 7'h79;
            4'd2:    cur_seg = 7'h24;
            4'd3:    cur_seg = 7'h30;
            4'd4:    cur_seg = 7'h19;
            4'd5:    cur_seg = 7'h12;
            4'd6:    cur_seg = 7'h02;
            4'd7:    cur_seg = 7'h78;
            4'd8:    cur_seg = 7'h00;
            4'd9:    cur_seg = 7'h10;
            default: cur_seg = 7'h3F;
        endcase
        suppress = (blink_phase && |(blink_mask & sel)) ||
                   ((idx == 3'd5) && lzb_en && (display[23:20] == 4'd0));
        lit = (div >= DIV_BLANK) && !suppress;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_n       <= 6'h3F;
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            frame_sync <= 1'b0;
        end else begin
            an_n       <= lit ? ~sel : 6'h3F;
            seg_n      <= lit ? cur_seg : 7'h7F;
            dp_n       <= !(lit && !blink_phase && (idx == 3'd2 || idx == 3'd4));
            frame_sync <= (div == '0) && (idx == 3'd0);
        end
    end

endmodule
